// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 constants: register numbers, exception codes and bit positions.
package cp0_pkg;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_EXL = 1;
  localparam int STATUS_IE  = 0;
  localparam int CAUSE_BD   = 31;
  localparam int CAUSE_TI   = 30;

  // MTC0-writable Status bits: IM[15:8], EXL, IE
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
endpackage

// File: rtl/cp0_regfile_if.sv
// Pipeline <-> CP0 bus: MFC0 read, MTC0 write, commit events, interrupt lines.
interface cp0_regfile_if;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_badv_we;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [5:0]  hw_int;
  logic [31:0] epc_out;
  logic [31:0] status_out;
  logic [31:0] cause_out;
  logic        int_pending;

  modport master (
    output raddr, we, waddr, wdata, exc_valid, exc_code, exc_pc, exc_bd,
           exc_badv_we, exc_badvaddr, eret, hw_int,
    input  rdata, epc_out, status_out, cause_out, int_pending
  );
  modport slave (
    input  raddr, we, waddr, wdata, exc_valid, exc_code, exc_pc, exc_bd,
           exc_badv_we, exc_badvaddr, eret, hw_int,
    output rdata, epc_out, status_out, cause_out, int_pending
  );
endinterface

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: Count ticks every COUNT_DIV cycles, TI latches on match.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  logic [1:0] div;
  logic       tick;

  assign tick = (div == 2'(COUNT_DIV - 1));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      div     <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      div <= tick ? 2'd0 : div + 2'd1;
      // software write wins over the tick; divider phase is left alone
      if (count_we)  count <= wdata;
      else if (tick) count <= count + 32'd1;
      if (compare_we) compare <= wdata;
      if (compare_we)                ti <= 1'b0;
      else if (count == compare)     ti <= 1'b1;
    end
  end
endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr/Count/Compare/Status/Cause/EPC, exception and ERET commit.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic           clk,
  input  logic           aresetn,
  cp0_regfile_if.slave   bus
);
  logic [31:0] badvaddr, epc, status, count, compare, cause;
  logic        bd, ti;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [4:0]  exccode;
  logic        mtc0;

  // commit events take the whole cycle; a same-cycle MTC0 is discarded
  assign mtc0 = bus.we & ~bus.exc_valid & ~bus.eret;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .aresetn    (aresetn),
    .count_we   (mtc0 && bus.waddr == CP0_COUNT),
    .compare_we (mtc0 && bus.waddr == CP0_COMPARE),
    .wdata      (bus.wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      badvaddr <= '0;
      epc      <= '0;
      status   <= RESET_STATUS;
      bd       <= 1'b0;
      ip_hw    <= '0;
      ip_sw    <= '0;
      exccode  <= '0;
    end else begin
      ip_hw <= {bus.hw_int[5] | ti, bus.hw_int[4:0]};
      if (bus.exc_valid) begin
        // nested exception keeps the original EPC/BD
        if (!status[STATUS_EXL]) begin
          epc <= bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
          bd  <= bus.exc_bd;
        end
        exccode            <= bus.exc_code;
        status[STATUS_EXL] <= 1'b1;
        if (bus.exc_badv_we) badvaddr <= bus.exc_badvaddr;
      end else if (bus.eret) begin
        status[STATUS_EXL] <= 1'b0;
      end else if (bus.we) begin
        case (bus.waddr)
          CP0_STATUS: status <= (status & ~STATUS_WMASK) | (bus.wdata & STATUS_WMASK);
          CP0_CAUSE:  ip_sw  <= bus.wdata[9:8];
          CP0_EPC:    epc    <= bus.wdata;
          default: ;
        endcase
      end
    end
  end

  assign cause = {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exccode, 2'b0};

  always_comb begin
    bus.rdata = 32'h0;
    case (bus.raddr)
      CP0_BADVADDR: bus.rdata = badvaddr;
      CP0_COUNT:    bus.rdata = count;
      CP0_COMPARE:  bus.rdata = compare;
      CP0_STATUS:   bus.rdata = status;
      CP0_CAUSE:    bus.rdata = cause;
      CP0_EPC:      bus.rdata = epc;
      default:      bus.rdata = 32'h0;
    endcase
  end

  assign bus.epc_out     = epc;
  assign bus.status_out  = status;
  assign bus.cause_out   = cause;
  assign bus.int_pending = status[STATUS_IE] & ~status[STATUS_EXL] &
                           |(cause[15:8] & status[15:8]);
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: reset, MTC0 masking, timer, exceptions, priority, async reset.
module tb_cp0_regfile;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  cp0_regfile_if bus ();
  cp0_regfile #(.COUNT_DIV(2), .RESET_STATUS(32'h0040_0000)) dut (
    .clk(clk), .aresetn(aresetn), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.exc_valid = 1'b0; bus.exc_code = '0; bus.exc_pc = '0; bus.exc_bd = 1'b0;
    bus.exc_badv_we = 1'b0; bus.exc_badvaddr = '0; bus.eret = 1'b0;
  endtask

  // one posedge, then return at the following negedge with strobes cleared
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    step();
  endtask

  task automatic mfc0(input logic [4:0] a, output logic [31:0] d);
    bus.raddr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    mfc0(5'd12, d); total++;
    if (d !== 32'h0040_0000) begin bad++; $display("FAIL reset_status got=%h exp=%h", d, 32'h0040_0000); end
    mfc0(5'd13, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_cause got=%h exp=0", d); end
    mfc0(5'd3, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_unmapped got=%h exp=0", d); end
    total++;
    if (bus.int_pending !== 1'b0) begin bad++; $display("FAIL reset_intp got=%b exp=0", bus.int_pending); end
  endtask

  task automatic test_write_masks();
    logic [31:0] d;
    // move Compare away from Count so TI stays clear for the mask checks
    mtc0(5'd11, 32'hFFFF_0000);
    mtc0(5'd12, 32'hFFFF_FFFF);
    mfc0(5'd12, d); total++;
    if (d !== 32'h0040_FF03) begin bad++; $display("FAIL status_mask got=%h exp=%h", d, 32'h0040_FF03); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    mfc0(5'd13, d); total++;
    if (d !== 32'h0000_0300) begin bad++; $display("FAIL cause_mask got=%h exp=%h", d, 32'h0000_0300); end
    total++;
    if (bus.int_pending !== 1'b0) begin bad++; $display("FAIL intp_exl got=%b exp=0", bus.int_pending); end
    mtc0(5'd8, 32'hDEAD_BEEF);
    mfc0(5'd8, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL badv_ro got=%h exp=0", d); end
    mtc0(5'd13, 32'h0);
    mtc0(5'd12, 32'h0);
  endtask

  task automatic test_timer();
    logic [31:0] d;
    int n = 0;
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    // Count reaches 5 after 9..10 edges, TI latches one edge later
    while (bus.cause_out[30] !== 1'b1 && n < 40) begin
      step(); n++;
    end
    total++;
    if (n < 10 || n > 11) begin bad++; $display("FAIL ti_latency got=%0d exp=10..11", n); end
    mfc0(5'd9, d); total++;
    if (d !== 32'd5 && d !== 32'd6) begin bad++; $display("FAIL count_at_ti got=%0d exp=5..6", d); end
    step();
    total++;
    if (bus.cause_out[15] !== 1'b1) begin bad++; $display("FAIL ip7_from_ti got=%b exp=1", bus.cause_out[15]); end
    mtc0(5'd12, 32'h0000_8001);
    total++;
    if (bus.int_pending !== 1'b1) begin bad++; $display("FAIL timer_intp got=%b exp=1", bus.int_pending); end
    mtc0(5'd11, 32'd100);
    total++;
    if (bus.cause_out[30] !== 1'b0) begin bad++; $display("FAIL ti_clear got=%b exp=0", bus.cause_out[30]); end
    step();
    total++;
    if (bus.int_pending !== 1'b0) begin bad++; $display("FAIL intp_clear got=%b exp=0", bus.int_pending); end
  endtask

  task automatic test_exception();
    logic [31:0] d;
    bus.exc_valid = 1'b1; bus.exc_code = 5'd4; bus.exc_pc = 32'hBFC0_0100;
    bus.exc_bd = 1'b1; bus.exc_badv_we = 1'b1; bus.exc_badvaddr = 32'h0000_0003;
    step();
    total++;
    if (bus.epc_out !== 32'hBFC0_00FC) begin bad++; $display("FAIL exc_epc got=%h exp=%h", bus.epc_out, 32'hBFC0_00FC); end
    total++;
    if (bus.cause_out[31] !== 1'b1) begin bad++; $display("FAIL exc_bd got=%b exp=1", bus.cause_out[31]); end
    total++;
    if (bus.cause_out[6:2] !== 5'd4) begin bad++; $display("FAIL exc_code got=%0d exp=4", bus.cause_out[6:2]); end
    total++;
    if (bus.status_out[1] !== 1'b1) begin bad++; $display("FAIL exc_exl got=%b exp=1", bus.status_out[1]); end
    mfc0(5'd8, d); total++;
    if (d !== 32'h3) begin bad++; $display("FAIL exc_badv got=%h exp=3", d); end
    bus.exc_valid = 1'b1; bus.exc_code = 5'd8; bus.exc_pc = 32'h8000_0000;
    step();
    total++;
    if (bus.epc_out !== 32'hBFC0_00FC) begin bad++; $display("FAIL nested_epc got=%h exp=%h", bus.epc_out, 32'hBFC0_00FC); end
    total++;
    if (bus.cause_out[6:2] !== 5'd8) begin bad++; $display("FAIL nested_code got=%0d exp=8", bus.cause_out[6:2]); end
  endtask

  task automatic test_back_to_back();
    bus.eret = 1'b1;
    step();
    bus.exc_valid = 1'b1; bus.exc_code = 5'd12; bus.exc_pc = 32'h0000_2000; bus.exc_bd = 1'b0;
    bus.eret = 1'b1; bus.we = 1'b1; bus.waddr = 5'd14; bus.wdata = 32'h0000_1234;
    step();
    total++;
    if (bus.epc_out !== 32'h0000_2000) begin bad++; $display("FAIL prio_epc got=%h exp=%h", bus.epc_out, 32'h0000_2000); end
    total++;
    if (bus.status_out[1] !== 1'b1) begin bad++; $display("FAIL prio_exl got=%b exp=1", bus.status_out[1]); end
    bus.eret = 1'b1;
    step();
    total++;
    if (bus.status_out[1] !== 1'b0) begin bad++; $display("FAIL eret_exl got=%b exp=0", bus.status_out[1]); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    bus.exc_valid = 1'b1; bus.exc_code = 5'd10; bus.exc_pc = 32'h0000_4000;
    step();
    mtc0(5'd9, 32'd7);
    mfc0(5'd9, d); total++;
    if (d !== 32'd7) begin bad++; $display("FAIL pre_reset_count got=%0d exp=7", d); end
    aresetn = 1'b0;
    #1;
    total++;
    if (bus.status_out !== 32'h0040_0000) begin bad++; $display("FAIL areset_status got=%h exp=%h", bus.status_out, 32'h0040_0000); end
    total++;
    if (bus.cause_out !== 32'h0 || bus.epc_out !== 32'h0) begin
      bad++; $display("FAIL areset_cause_epc got=%h/%h exp=0/0", bus.cause_out, bus.epc_out);
    end
    mfc0(5'd9, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL areset_count got=%h exp=0", d); end
    mfc0(5'd8, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL areset_badv got=%h exp=0", d); end
    total++;
    if (bus.int_pending !== 1'b0) begin bad++; $display("FAIL areset_intp got=%b exp=0", bus.int_pending); end
  endtask

  initial begin
    idle_inputs();
    bus.raddr = '0;
    bus.hw_int = '0;
    #23;
    test_reset();
    @(negedge clk);
    aresetn = 1'b1;
    test_write_masks();
    test_timer();
    test_exception();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file. Answers the CP0 half of the 7-bit register address space: addresses {2'b01, rd} that the ID stage generates for MFC0, MTC0 and ERET.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Takes exception/ERET commit from the WB/commit stage, runs the Count/Compare timer, and raises the interrupt request back to the pipeline.

Parameters:
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (legal range 1..4).
- RESET_STATUS, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  core clock
- aresetn  in  1  asynchronous active-low reset
- raddr  in  5  CP0 read register number (MFC0 rd)
- rdata  out  32  read data, combinational from current state
- we  in  1  MTC0 commit strobe
- waddr  in  5  MTC0 destination register number
- wdata  in  32  MTC0 data
- exc_valid  in  1  exception commit this cycle
- exc_code  in  5  ExcCode (0 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov)
- exc_pc  in  32  PC of the faulting instruction
- exc_bd  in  1  faulting instruction is in a delay slot
- exc_badv_we  in  1  update BadVAddr
- exc_badvaddr  in  32  faulting address
- eret  in  1  ERET commit this cycle
- hw_int  in  6  external interrupt lines, level-sensitive
- epc_out  out  32  current EPC (ERET target)
- status_out  out  32  current Status
- cause_out  out  32  current Cause
- int_pending  out  1  interrupt request to the pipeline

Behaviour:
Reset (async, aresetn=0):
- Status=RESET_STATUS.
- Cause, EPC, BadVAddr, Count and Compare = 0.
- Divider counter = 0; TI = 0.
- Outputs follow from these values; int_pending=0.

Register map:
- 8 BadVAddr: read-only to MTC0.
- 9 Count: read/write.
- 11 Compare: read/write.
- 12 Status: writable bits IM[15:8], EXL[1], IE[0]. BEV[22] is constant 1. All other bits read 0.
- 13 Cause: writable bits IP[9:8] only. BD[31], TI[30], IP[15:10] and ExcCode[6:2] are hardware-owned. Other bits read 0.
- 14 EPC: read/write.
- Any other raddr reads 32'h0. Writes to other addresses are ignored.

Read: rdata = register value before this edge. No write bypass; the pipeline forwards.

Timer:
- Divider counts 0..COUNT_DIV-1. On wrap, Count <= Count+1 (mod 2^32).
- MTC0 to Count overrides the tick in that cycle; the divider is not reset.
- TI sets on the edge after Count==Compare, unless Compare is written that cycle.
- MTC0 to Compare clears TI. The clear wins over a match in the same cycle.

Cause IP:
- Cause[15:10] <= {hw_int[5] | TI, hw_int[4:0]}, sampled every cycle.

Interrupt request:
- int_pending = Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]).
- Combinational from registered state.

Exception commit (exc_valid=1):
- If Status.EXL==0: EPC <= exc_bd ? exc_pc-4 : exc_pc, and Cause.BD <= exc_bd.
- If Status.EXL==1: EPC and BD are unchanged.
- Always: Cause.ExcCode <= exc_code and Status.EXL <= 1.
- If exc_badv_we: BadVAddr <= exc_badvaddr.

ERET: Status.EXL <= 0.

Same-cycle priority: exc_valid > eret > we.
- An MTC0 in the same cycle as exc_valid or eret is dropped entirely.
- Timer tick and IP sampling proceed regardless.

Decomposition:
- Shared package cp0_pkg:
  - Register numbers: CP0_BADVADDR=8, CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14.
  - ExcCode constants: EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV.
  - Bit-position constants: STATUS_EXL, STATUS_IE, CAUSE_BD, CAUSE_TI.
- Sub-module cp0_timer: divider, Count, Compare and TI, with ports for the Count and Compare write strobes.

Test Plan:
- Reset, then MFC0 from 12, 13 and 3 -> rdata = 32'h0040_0000, 32'h0, 32'h0. int_pending=0.
- MTC0 Status=32'hFFFF_FFFF, then read 12 -> 32'h0040_FF03. MTC0 Cause=32'hFFFF_FFFF, then read 13 -> 32'h0000_0300 and int_pending=0, because EXL=1 was written.
- MTC0 Compare=5, then Count=0, COUNT_DIV=2 -> Count==5 about 10 cycles later, then TI=1 and Cause[30]=1. Status=32'h0000_8001 -> int_pending=1. MTC0 Compare=100 -> TI=0 next cycle and int_pending=0.
- exc_valid with exc_code=4, exc_pc=32'hBFC0_0100, exc_bd=1, exc_badv_we=1, exc_badvaddr=32'h0000_0003 -> EPC=32'hBFC0_00FC, Cause.BD=1, ExcCode=4, EXL=1, BadVAddr=3. A second exc_valid with exc_pc=32'h8000_0000 -> EPC unchanged, ExcCode updated.
- exc_valid, eret and we(EPC=32'h1234) in the same cycle -> exception applied, EXL=1, EPC from exc_pc not 32'h1234. Then eret alone -> EXL=0.
- Drop aresetn while Count=7 and EXL=1, mid-divider -> all registers return to reset values immediately, without a clock edge.
